block_lock_ctrl_rx: RTL and testbench

//  Rx block-lock controller for the 64b/66b path, per IEEE 802.3 cl.49 lock FSM.

---
 rtl/block_lock_ctrl_rx_if.sv | 27 ++
 rtl/block_lock_ctrl_rx.sv | 126 ++++++++++++
 tb/tb_block_lock_ctrl_rx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/block_lock_ctrl_rx_if.sv
// Block-lock controller bus: rx gearbox side (valid/head/data in, slip back)
// and descrambler side (registered valid/head/data, lock and slip count).
interface block_lock_ctrl_rx_if #(
  parameter int DATA_W = 64
);
  logic              valid_i;
  logic [1:0]        head_i;
  logic [DATA_W-1:0] data_i;
  logic              slip_o;
  logic              lock_o;
  logic              valid_o;
  logic [1:0]        head_o;
  logic [DATA_W-1:0] data_o;
  logic [7:0]        slip_cnt_o;

  // Gearbox/test driver side.
  modport master (
    output valid_i, head_i, data_i,
    input  slip_o, lock_o, valid_o, head_o, data_o, slip_cnt_o
  );

  // Lock controller side.
  modport slave (
    input  valid_i, head_i, data_i,
    output slip_o, lock_o, valid_o, head_o, data_o, slip_cnt_o
  );
endinterface

// File: rtl/block_lock_ctrl_rx.sv
// Rx block-lock controller for the 64b/66b path. Tests sync headers over
// fixed windows, requests one-bit gearbox slips on bad headers, asserts lock
// after a clean window, and registers the block towards the descrambler.
module block_lock_ctrl_rx #(
  parameter int DATA_W       = 64,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 4
) (
  input logic                clk,
  input logic                nreset,
  block_lock_ctrl_rx_if.slave bus
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   CNT_END   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_END   = INV_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SLIP_WAIT);

  // Lock FSM states.
  localparam logic [0:0] ST_TEST = 1'b0;
  localparam logic [0:0] ST_SLIP = 1'b1;

  logic [0:0]        state;
  logic [SH_W-1:0]   sh_cnt;
  logic [INV_W-1:0]  invld_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lock;
  logic              slip;
  logic [7:0]        slip_cnt;
  logic              valid_q;
  logic [1:0]        head_q;
  logic [DATA_W-1:0] data_q;

  logic              sh_ok;
  logic [SH_W-1:0]   cn;
  logic [INV_W-1:0]  in_n;

  // A header is valid only when its two bits differ (01 or 10).
  assign sh_ok = bus.head_i[1] ^ bus.head_i[0];
  assign cn    = sh_cnt + SH_W'(1);
  assign in_n  = invld_cnt + INV_W'(1);

  // Lock FSM: header window counting, slip requests and slip hold-off.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= ST_TEST;
      sh_cnt    <= '0;
      invld_cnt <= '0;
      wait_cnt  <= '0;
      lock      <= 1'b0;
      slip      <= 1'b0;
      slip_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every decision below see the
      // pre-edge lock/counters, which the datapath's valid gating relies on.
      slip <= 1'b0;
      case (state)
        ST_TEST: begin
          if (bus.valid_i) begin
            if (sh_ok) begin
              if (cn == CNT_END) begin
                sh_cnt    <= '0;
                invld_cnt <= '0;
                if (invld_cnt == '0) lock <= 1'b1;
              end else begin
                sh_cnt <= cn;
              end
            end else if (!lock || in_n == INV_END) begin
              state     <= ST_SLIP;
              lock      <= 1'b0;
              slip      <= 1'b1;
              sh_cnt    <= '0;
              invld_cnt <= '0;
              wait_cnt  <= WAIT_INIT;
              if (slip_cnt != 8'hff) slip_cnt <= slip_cnt + 8'd1;
            end else if (cn == CNT_END) begin
              // Window closes with tolerable errors: keep lock, start fresh.
              sh_cnt    <= '0;
              invld_cnt <= '0;
            end else begin
              sh_cnt    <= cn;
              invld_cnt <= in_n;
            end
          end
        end
        ST_SLIP: begin
          // Give the gearbox SLIP_WAIT cycles to settle; headers ignored.
          if (wait_cnt <= WAIT_W'(1)) begin
            state    <= ST_TEST;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        default: state <= ST_TEST;
      endcase
    end
  end

  // Datapath register: capture block on valid, qualify with previous lock.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= bus.valid_i & lock;
      if (bus.valid_i) begin
        head_q <= bus.head_i;
        data_q <= bus.data_i;
      end
    end
  end

  assign bus.slip_o     = slip;
  assign bus.lock_o     = lock;
  assign bus.valid_o    = valid_q;
  assign bus.head_o     = head_q;
  assign bus.data_o     = data_q;
  assign bus.slip_cnt_o = slip_cnt;

endmodule

// File: tb/tb_block_lock_ctrl_rx.sv
// Self-checking bench for block_lock_ctrl_rx: randomized blocks compared
// cycle by cycle against a behavioural lock model, plus directed checks.
module tb_block_lock_ctrl_rx;

  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  block_lock_ctrl_rx_if #(.DATA_W(DATA_W)) bus ();

  block_lock_ctrl_rx #(
    .DATA_W(DATA_W), .SH_CNT_MAX(64), .SH_INVLD_MAX(16), .SLIP_WAIT(4)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: window position, bad count, hold-off cycles left.
  int          m_win, m_bad, m_hold, m_slips;
  bit          m_lock, m_slip, m_valid;
  logic [1:0]  m_head;
  logic [63:0] m_data;

  task automatic model_step(input logic rn, input logic v, input logic [1:0] h,
                            input logic [63:0] d);
    bit prev_lock;
    if (!rn) begin
      m_win = 0; m_bad = 0; m_hold = 0; m_slips = 0;
      m_lock = 0; m_slip = 0; m_valid = 0; m_head = '0; m_data = '0;
      return;
    end
    prev_lock = m_lock;
    m_slip    = 0;
    if (v) begin
      m_head = h;
      m_data = d;
    end
    if (m_hold > 0) begin
      m_hold--;
    end else if (v) begin
      m_win++;
      if (h == 2'b01 || h == 2'b10) begin
        if (m_win == 64) begin
          if (m_bad == 0) m_lock = 1;
          m_win = 0; m_bad = 0;
        end
      end else begin
        m_bad++;
        if (!m_lock || m_bad == 16) begin
          m_lock = 0; m_slip = 1; m_win = 0; m_bad = 0; m_hold = 4;
          if (m_slips < 255) m_slips++;
        end else if (m_win == 64) begin
          m_win = 0; m_bad = 0;
        end
      end
    end
    m_valid = v & prev_lock;
  endtask

  // One clock: drive, let the edge happen, update model, compare #1 later.
  task automatic cycle(input logic rn, input logic v, input logic [1:0] h,
                       input logic [63:0] d);
    nreset      = rn;
    bus.valid_i = v;
    bus.head_i  = h;
    bus.data_i  = d;
    @(posedge clk);
    model_step(rn, v, h, d);
    #1;
    check("lock",     64'(bus.lock_o),     64'(m_lock));
    check("slip",     64'(bus.slip_o),     64'(m_slip));
    check("valid",    64'(bus.valid_o),    64'(m_valid));
    check("head",     64'(bus.head_o),     64'(m_head));
    check("data",     bus.data_o,          m_data);
    check("slip_cnt", 64'(bus.slip_cnt_o), 64'(m_slips));
  endtask

  function automatic logic [1:0] good_head();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_head();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic good();  cycle(1'b1, 1'b1, good_head(), rnd_data()); endtask
  task automatic bad();   cycle(1'b1, 1'b1, bad_head(),  rnd_data()); endtask
  task automatic do_reset();
    repeat (2) cycle(1'b0, $urandom_range(0, 1), 2'($urandom), rnd_data());
  endtask

  initial begin
    nreset      = 1'b0;
    bus.valid_i = 1'b0;
    bus.head_i  = '0;
    bus.data_i  = '0;

    // 1: reset state, lock after 64 good headers, valid_o from block 65.
    do_reset();
    check("rst_lock", 64'(bus.lock_o), 64'd0);
    check("rst_data", bus.data_o, 64'd0);
    repeat (63) good();
    check("t1_lock63", 64'(bus.lock_o), 64'd0);
    good();
    check("t1_lock64", 64'(bus.lock_o), 64'd1);
    check("t1_valid64", 64'(bus.valid_o), 64'd0);
    good();
    check("t1_valid65", 64'(bus.valid_o), 64'd1);

    // 2: unlocked, block 10 bad -> slip, headers ignored for 4 cycles.
    do_reset();
    repeat (9) good();
    bad();
    check("t2_slip", 64'(bus.slip_o), 64'd1);
    check("t2_cnt", 64'(bus.slip_cnt_o), 64'd1);
    repeat (4) begin
      bad();
      check("t2_ignored", 64'(bus.slip_o), 64'd0);
    end
    bad();
    check("t2_reslip", 64'(bus.slip_o), 64'd1);
    check("t2_cnt2", 64'(bus.slip_cnt_o), 64'd2);

    // 3: locked, 15 scattered bad headers in a window held; 16 drop lock.
    do_reset();
    repeat (64) good();
    begin
      bit pos [64];
      for (int i = 0; i < 64; i++) pos[i] = (i < 15);
      for (int i = 63; i > 0; i--) begin
        int j = $urandom_range(0, i);
        bit t = pos[i];
        pos[i] = pos[j];
        pos[j] = t;
      end
      for (int i = 0; i < 64; i++) begin
        if (pos[i]) bad(); else good();
      end
    end
    check("t3_held", 64'(bus.lock_o), 64'd1);
    repeat (20) good();
    repeat (15) bad();
    check("t3_held15", 64'(bus.lock_o), 64'd1);
    bad();
    check("t3_drop", 64'(bus.lock_o), 64'd0);
    check("t3_slip", 64'(bus.slip_o), 64'd1);

    // 4: gearbox misaligned by 5 bits, one-bit shift per slip pulse.
    do_reset();
    begin
      int off = 5;
      int n   = 0;
      logic [65:0] blk;
      while (!bus.lock_o && n < 3000) begin
        blk = {$urandom(), $urandom(), good_head()};
        cycle(1'b1, 1'b1, {blk[off+1], blk[off]}, blk[65:2]);
        if (bus.slip_o) off = (off == 0) ? 65 : off - 1;
        n++;
      end
      check("t4_lock", 64'(bus.lock_o), 64'd1);
      check("t4_slips", 64'(bus.slip_cnt_o), 64'd5);
      check("t4_aligned", 64'(off), 64'd0);
    end

    // 5: valid_i gaps carry garbage headers that must be ignored.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      if ($urandom_range(0, 1) == 1) cycle(1'b1, 1'b0, bad_head(), rnd_data());
      good();
    end
    check("t5_lock", 64'(bus.lock_o), 64'd1);
    cycle(1'b1, 1'b0, bad_head(), rnd_data());
    check("t5_gap_lock", 64'(bus.lock_o), 64'd1);

    // 6: reset mid-slip and mid-lock, relock, slip counter saturation.
    do_reset();
    repeat (3) good();
    bad();
    bad();
    cycle(1'b0, 1'b1, bad_head(), rnd_data());
    check("t6_rst_slip", 64'(bus.slip_o), 64'd0);
    check("t6_rst_cnt", 64'(bus.slip_cnt_o), 64'd0);
    repeat (6) begin
      good();
      check("t6_no_slip", 64'(bus.slip_o), 64'd0);
    end
    repeat (58) good();
    check("t6_relock", 64'(bus.lock_o), 64'd1);
    cycle(1'b0, 1'b1, good_head(), rnd_data());
    check("t6_rst_lock", 64'(bus.lock_o), 64'd0);
    check("t6_rst_valid", 64'(bus.valid_o), 64'd0);
    check("t6_rst_head", 64'(bus.head_o), 64'd0);
    repeat (63) good();
    check("t6_lock63", 64'(bus.lock_o), 64'd0);
    good();
    check("t6_lock64", 64'(bus.lock_o), 64'd1);
    repeat (1400) bad();
    check("t6_sat", 64'(bus.slip_cnt_o), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
